io_ccff_prog_ctrl: RTL and testbench

//   Programming controller directly upstream of the IO logical tile configuration chain.

---
 rtl/ccff_prog_pkg.sv | 33 +++
 rtl/ccff_crc16_serial.sv | 37 +++
 rtl/io_ccff_prog_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_io_ccff_prog_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_prog_pkg.sv
// ---------------------------------------------------------------------------
// ccff_prog_pkg
// Shared types and helpers for the IO configuration-chain programming
// controller: FSM state encoding, CRC-16-CCITT constants, the serial CRC
// step function and the bitstream word-count helper.
// ---------------------------------------------------------------------------
package ccff_prog_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_VERIFY,
    S_RELEASE,
    S_DONE,
    S_ERROR
  } prog_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Number of bitstream words needed to cover the whole chain.
  function automatic int words_total(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // One serial CRC-16-CCITT update (MSB-first shift register form).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// ---------------------------------------------------------------------------
// ccff_crc16_serial
// Bit-serial CRC-16-CCITT accumulator, one bit per enabled cycle.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (crc returns to CRC_INIT)
//   init   in   synchronous re-seed to CRC_INIT (wins over en)
//   en     in   fold bit_in into the CRC this cycle
//   bit_in in   serial data bit
//   crc    out  current CRC register value
// ---------------------------------------------------------------------------
module ccff_crc16_serial
  import ccff_prog_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= CRC_INIT;
    end else if (init) begin
      r_crc <= CRC_INIT;
    end else if (en) begin
      r_crc <= crc16_step(r_crc, bit_in);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/io_ccff_prog_ctrl.sv
// ---------------------------------------------------------------------------
// io_ccff_prog_ctrl
// Loads the IO logical-tile configuration chain from a valid/ready word
// stream, optionally verifies it by rotating the chain once through a CRC,
// and releases IO isolation a fixed delay after a good load.
// Ports:
//   prog_clk      in   programming clock
//   prog_reset_n  in   asynchronous active-low reset
//   start         in   begin programming (ignored while busy)
//   cfg_data      in   bitstream word, MSB shifted first
//   cfg_valid     in   cfg_data valid
//   cfg_ready     out  word accepted when cfg_valid & cfg_ready
//   ccff_head     out  serial bit into the chain
//   ccff_tail     in   serial bit out of the chain end
//   ccff_clk_en   out  chain clock-gate enable (chain shifts when 1)
//   IO_ISOL_N     out  0 = IO isolated, 1 = released
//   busy          out  programming / verify / release delay in progress
//   done          out  load (and verify) succeeded, sticky until next start
//   crc_err       out  verify mismatch, sticky until next start
// ---------------------------------------------------------------------------
module io_ccff_prog_ctrl
  import ccff_prog_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int VERIFY    = 1,
  parameter int ISOL_DLY  = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_clk_en,
  output logic              IO_ISOL_N,
  output logic              busy,
  output logic              done,
  output logic              crc_err
);

  localparam int WT     = words_total(CHAIN_LEN, WORD_W);
  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(WT + 1);
  localparam int IDX_W  = $clog2(WORD_W);
  localparam int ISO_W  = $clog2(ISOL_DLY + 1);

  prog_state_e       r_state;
  prog_state_e       w_state_next;
  logic [WORD_W-1:0] r_hold;
  logic              r_hold_full;
  logic [IDX_W-1:0]  r_idx;
  logic [WCNT_W-1:0] r_words_rem;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  r_vfy_cnt;
  logic [ISO_W-1:0]  r_isol_cnt;
  logic              r_head;

  logic        w_start;
  logic        w_shift;
  logic        w_shift_bit;
  logic        w_idx_last;
  logic        w_last_bit;
  logic        w_vfy_last;
  logic        w_accept;
  logic        w_crc_match;
  logic [15:0] w_crc_wr;
  logic [15:0] w_crc_rd;

  assign w_start     = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign w_shift     = (r_state == S_SHIFT) && r_hold_full;
  assign w_shift_bit = r_hold[IDX_W'(WORD_W - 1) - r_idx];
  assign w_idx_last  = (r_idx == IDX_W'(WORD_W - 1));
  assign w_last_bit  = w_shift && (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_vfy_last  = (r_vfy_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_accept    = cfg_valid && cfg_ready;

  // crc_rd registers the tail bit at the end of the last verify cycle, so
  // the decision uses the value it is about to take.
  assign w_crc_match = (crc16_step(w_crc_rd, ccff_tail) == w_crc_wr);

  ccff_crc16_serial u_crc_wr (
    .clk    (prog_clk),
    .rst_n  (prog_reset_n),
    .init   (w_start),
    .en     (w_shift),
    .bit_in (w_shift_bit),
    .crc    (w_crc_wr)
  );

  ccff_crc16_serial u_crc_rd (
    .clk    (prog_clk),
    .rst_n  (prog_reset_n),
    .init   (w_start),
    .en     (r_state == S_VERIFY),
    .bit_in (ccff_tail),
    .crc    (w_crc_rd)
  );

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cfg_ready    = 1'b0;
    ccff_clk_en  = 1'b0;
    ccff_head    = r_head;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        // Refill either into an empty hold register or in the same cycle the
        // last bit of the current word leaves, so words stream without gaps.
        cfg_ready = (!r_hold_full || w_idx_last) && (r_words_rem != '0) && !w_last_bit;
        if (r_hold_full) begin
          ccff_clk_en = 1'b1;
          ccff_head   = w_shift_bit;
          if (w_last_bit) w_state_next = (VERIFY != 0) ? S_VERIFY : S_RELEASE;
        end
      end
      S_VERIFY: begin
        // Full rotation: tail fed straight back into head restores the chain.
        ccff_clk_en = 1'b1;
        ccff_head   = ccff_tail;
        if (w_vfy_last) w_state_next = w_crc_match ? S_RELEASE : S_ERROR;
      end
      S_RELEASE: begin
        if (r_isol_cnt == ISO_W'(ISOL_DLY - 1)) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_idx       <= '0;
      r_words_rem <= '0;
      r_bit_cnt   <= '0;
      r_vfy_cnt   <= '0;
      r_isol_cnt  <= '0;
      r_head      <= 1'b0;
    end else if (w_start) begin
      r_hold_full <= 1'b0;
      r_idx       <= '0;
      r_words_rem <= WCNT_W'(WT);
      r_bit_cnt   <= '0;
      r_vfy_cnt   <= '0;
      r_isol_cnt  <= '0;
    end else begin
      if (w_shift) begin
        r_head    <= w_shift_bit;
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        // On the final chain bit any remaining word bits are dropped.
        if (w_idx_last || w_last_bit) begin
          r_idx       <= '0;
          r_hold_full <= w_accept;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else if (w_accept) begin
        r_hold_full <= 1'b1;
        r_idx       <= '0;
      end
      if (w_accept) begin
        r_hold      <= cfg_data;
        r_words_rem <= r_words_rem - WCNT_W'(1);
      end
      if (r_state == S_VERIFY)  r_vfy_cnt  <= r_vfy_cnt + CNT_W'(1);
      if (r_state == S_RELEASE) r_isol_cnt <= r_isol_cnt + ISO_W'(1);
    end
  end

  assign busy      = (r_state == S_SHIFT) || (r_state == S_VERIFY) || (r_state == S_RELEASE);
  assign done      = (r_state == S_DONE);
  assign crc_err   = (r_state == S_ERROR);
  assign IO_ISOL_N = (r_state == S_DONE);

endmodule

// File: tb/tb_io_ccff_prog_ctrl.sv
module tb_io_ccff_prog_ctrl;

  logic clk = 1'b0;
  logic prog_reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 10-bit chain, 4-bit words, verify enabled
  logic       start_a = 1'b0, valid_a = 1'b0;
  logic [3:0] data_a = '0;
  logic       ready_a, head_a, tail_a, en_a, isol_a, busy_a, done_a, err_a;
  logic [9:0] chain_a = '0;
  logic [9:0] flip_mask_a = '0;

  // DUT B: 8-bit chain, 8-bit words, no verify
  logic       start_b = 1'b0, valid_b = 1'b0;
  logic [7:0] data_b = '0;
  logic       ready_b, head_b, tail_b, en_b, isol_b, busy_b, done_b, err_b;
  logic [7:0] chain_b = '0;

  int n_checks = 0;
  int n_fail   = 0;

  io_ccff_prog_ctrl #(.CHAIN_LEN(10), .WORD_W(4), .VERIFY(1), .ISOL_DLY(4)) dut_a (
    .prog_clk(clk), .prog_reset_n(prog_reset_n), .start(start_a),
    .cfg_data(data_a), .cfg_valid(valid_a), .cfg_ready(ready_a),
    .ccff_head(head_a), .ccff_tail(tail_a), .ccff_clk_en(en_a),
    .IO_ISOL_N(isol_a), .busy(busy_a), .done(done_a), .crc_err(err_a)
  );

  io_ccff_prog_ctrl #(.CHAIN_LEN(8), .WORD_W(8), .VERIFY(0), .ISOL_DLY(4)) dut_b (
    .prog_clk(clk), .prog_reset_n(prog_reset_n), .start(start_b),
    .cfg_data(data_b), .cfg_valid(valid_b), .cfg_ready(ready_b),
    .ccff_head(head_b), .ccff_tail(tail_b), .ccff_clk_en(en_b),
    .IO_ISOL_N(isol_b), .busy(busy_b), .done(done_b), .crc_err(err_b)
  );

  // Chain models: plain shift registers clocked when the gate enable is high.
  assign tail_a = chain_a[9];
  assign tail_b = chain_b[7];
  always @(posedge clk) begin
    chain_a <= (en_a ? {chain_a[8:0], head_a} : chain_a) ^ flip_mask_a;
    if (en_b) chain_b <= {chain_b[6:0], head_b};
  end

  task automatic test_reset;
    prog_reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({ready_a, head_a, en_a, isol_a, busy_a, done_a, err_a} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_a: outputs %b expected 0000000",
               {ready_a, head_a, en_a, isol_a, busy_a, done_a, err_a});
    end
    n_checks++;
    if ({ready_b, head_b, en_b, isol_b, busy_b, done_b, err_b} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_b: outputs %b expected 0000000",
               {ready_b, head_b, en_b, isol_b, busy_b, done_b, err_b});
    end
    prog_reset_n = 1'b1;
    valid_a = 1'b1;
    data_a  = 4'h9;
    @(negedge clk);
    #1;
    n_checks++;
    if ({ready_a, busy_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_no_accept: ready,busy=%b expected 00", {ready_a, busy_a});
    end
    valid_a = 1'b0;
    $display("txn reset: both controllers idle, isolated");
  endtask

  // One programming run on DUT A, cycle by cycle against a bit-stream model.
  task automatic run_a(input string tag, input bit fixed, input bit gap_rand, input int gap_max,
                       input bit flip, input bit poke, input int abort_at);
    logic [3:0] words [3];
    logic [9:0] exp_chain;
    int  acc_words, acc_bits, shifted, vcnt, rcnt, gap;
    bit  finished, exp_ready;
    logic prev_head;
    if (fixed) begin
      words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hC;
    end else begin
      for (int i = 0; i < 3; i++) words[i] = 4'($urandom);
    end
    for (int k = 0; k < 10; k++) exp_chain[9-k] = words[k/4][3-(k%4)];

    @(negedge clk);
    start_a = 1'b1;
    valid_a = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    #1;
    n_checks++;
    if ({busy_a, done_a, err_a, isol_a, en_a} !== 5'b10000) begin
      n_fail++;
      $display("FAIL %s start: busy,done,err,isol,en=%b expected 10000", tag,
               {busy_a, done_a, err_a, isol_a, en_a});
    end
    prev_head = head_a;
    acc_words = 0; acc_bits = 0; shifted = 0; vcnt = 0; rcnt = 0; gap = 0;
    finished = 1'b0;

    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      valid_a     = (acc_words < 3) && (gap == 0);
      data_a      = valid_a ? words[acc_words] : 4'($urandom);
      start_a     = poke && ((shifted == 5) || (shifted == 10 && vcnt == 3));
      flip_mask_a = (flip && shifted == 10 && vcnt == 2) ? 10'h010 : 10'h000;
      #1;
      if (abort_at >= 0 && shifted == abort_at) begin
        prog_reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ready_a, head_a, en_a, isol_a, busy_a, done_a, err_a} !== 7'b0) begin
          n_fail++;
          $display("FAIL %s async_reset: outputs %b expected 0000000", tag,
                   {ready_a, head_a, en_a, isol_a, busy_a, done_a, err_a});
        end
        valid_a = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        prog_reset_n = 1'b1;
        finished = 1'b1;
      end else if (shifted < 10) begin
        exp_ready = (acc_words < 3) && (acc_bits - shifted <= 1);
        n_checks++;
        if (ready_a !== exp_ready) begin
          n_fail++;
          $display("FAIL %s ready bit%0d: got %b expected %b", tag, shifted, ready_a, exp_ready);
        end
        if (acc_bits - shifted > 0) begin
          n_checks++;
          if ({en_a, head_a} !== {1'b1, exp_chain[9-shifted]}) begin
            n_fail++;
            $display("FAIL %s shift bit%0d: en,head=%b expected %b", tag, shifted,
                     {en_a, head_a}, {1'b1, exp_chain[9-shifted]});
          end
          shifted++;
        end else begin
          n_checks++;
          if ({en_a, head_a} !== {1'b0, prev_head}) begin
            n_fail++;
            $display("FAIL %s stall: en,head=%b expected %b", tag, {en_a, head_a}, {1'b0, prev_head});
          end
        end
      end else if (vcnt < 10) begin
        if (vcnt == 0) begin
          n_checks++;
          if (chain_a !== exp_chain) begin
            n_fail++;
            $display("FAIL %s loaded_chain: got %b expected %b", tag, chain_a, exp_chain);
          end
        end
        n_checks++;
        if ({en_a, head_a, ready_a, busy_a} !== {1'b1, tail_a, 1'b0, 1'b1}) begin
          n_fail++;
          $display("FAIL %s verify%0d: en,head,ready,busy=%b expected %b", tag, vcnt,
                   {en_a, head_a, ready_a, busy_a}, {1'b1, tail_a, 1'b0, 1'b1});
        end
        vcnt++;
      end else if (flip) begin
        n_checks++;
        if ({err_a, done_a, isol_a, busy_a, en_a} !== 5'b10000) begin
          n_fail++;
          $display("FAIL %s crc_error: err,done,isol,busy,en=%b expected 10000", tag,
                   {err_a, done_a, isol_a, busy_a, en_a});
        end
        finished = 1'b1;
      end else if (rcnt < 4) begin
        if (rcnt == 0) begin
          n_checks++;
          if (chain_a !== exp_chain) begin
            n_fail++;
            $display("FAIL %s chain_after_verify: got %b expected %b", tag, chain_a, exp_chain);
          end
        end
        n_checks++;
        if ({en_a, isol_a, busy_a, done_a, ready_a} !== 5'b00100) begin
          n_fail++;
          $display("FAIL %s release%0d: en,isol,busy,done,ready=%b expected 00100", tag, rcnt,
                   {en_a, isol_a, busy_a, done_a, ready_a});
        end
        rcnt++;
      end else begin
        n_checks++;
        if ({isol_a, done_a, busy_a, err_a, en_a} !== 5'b11000) begin
          n_fail++;
          $display("FAIL %s done: isol,done,busy,err,en=%b expected 11000", tag,
                   {isol_a, done_a, busy_a, err_a, en_a});
        end
        finished = 1'b1;
      end
      if (!finished) begin
        if (valid_a && ready_a) begin
          acc_words++;
          acc_bits += 4;
          gap = gap_rand ? int'($urandom_range(0, gap_max)) : gap_max;
        end else if (gap > 0) begin
          gap--;
        end
        prev_head = head_a;
        @(negedge clk);
      end
    end
    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL %s timeout: run did not complete in 200 cycles", tag);
    end
    valid_a = 1'b0;
    start_a = 1'b0;
    flip_mask_a = '0;
    $display("txn %s: words %h %h %h expected chain %b", tag, words[0], words[1], words[2], exp_chain);
  endtask

  task automatic test_back_to_back;
    run_a("back_to_back", 1'b1, 1'b0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_valid_stall;
    run_a("valid_stall", 1'b1, 1'b0, 3, 1'b0, 1'b0, -1);
  endtask

  task automatic test_crc_error;
    run_a("crc_error", 1'b1, 1'b0, 0, 1'b1, 1'b0, -1);
    run_a("after_error", 1'b1, 1'b0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_mid_reset;
    run_a("mid_reset", 1'b1, 1'b0, 0, 1'b0, 1'b0, 6);
    run_a("reprogram", 1'b1, 1'b0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_start_ignored;
    run_a("start_ignored", 1'b0, 1'b1, 2, 1'b0, 1'b1, -1);
  endtask

  task automatic test_random;
    for (int r = 0; r < 5; r++) run_a("random", 1'b0, 1'b1, 3, 1'b0, 1'b0, -1);
  endtask

  task automatic test_no_verify;
    logic [7:0] word;
    int  shifted, rcnt, acc;
    bit  finished, exp_ready;
    word = 8'h3C;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    #1;
    n_checks++;
    if ({busy_b, done_b, err_b, isol_b} !== 4'b1000) begin
      n_fail++;
      $display("FAIL nv start: busy,done,err,isol=%b expected 1000", {busy_b, done_b, err_b, isol_b});
    end
    shifted = 0; rcnt = 0; acc = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
      valid_b = 1'b1;   // held high throughout: only one word may ever be taken
      data_b  = word;
      #1;
      if (shifted < 8) begin
        exp_ready = (acc == 0);
        n_checks++;
        if (ready_b !== exp_ready) begin
          n_fail++;
          $display("FAIL nv ready bit%0d: got %b expected %b", shifted, ready_b, exp_ready);
        end
        if (acc > 0) begin
          n_checks++;
          if ({en_b, head_b} !== {1'b1, word[7-shifted]}) begin
            n_fail++;
            $display("FAIL nv shift bit%0d: en,head=%b expected %b", shifted, {en_b, head_b},
                     {1'b1, word[7-shifted]});
          end
          shifted++;
        end else begin
          n_checks++;
          if (en_b !== 1'b0) begin
            n_fail++;
            $display("FAIL nv stall: en=%b expected 0", en_b);
          end
        end
      end else if (rcnt < 4) begin
        if (rcnt == 0) begin
          n_checks++;
          if (chain_b !== 8'b00111100) begin
            n_fail++;
            $display("FAIL nv chain: got %b expected 00111100", chain_b);
          end
        end
        n_checks++;
        if ({en_b, ready_b, isol_b, busy_b, done_b} !== 5'b00010) begin
          n_fail++;
          $display("FAIL nv release%0d: en,ready,isol,busy,done=%b expected 00010", rcnt,
                   {en_b, ready_b, isol_b, busy_b, done_b});
        end
        rcnt++;
      end else begin
        n_checks++;
        if ({isol_b, done_b, busy_b, err_b, ready_b, en_b} !== 6'b110000) begin
          n_fail++;
          $display("FAIL nv done: isol,done,busy,err,ready,en=%b expected 110000",
                   {isol_b, done_b, busy_b, err_b, ready_b, en_b});
        end
        finished = 1'b1;
      end
      if (!finished) begin
        if (valid_b && ready_b) acc++;
        @(negedge clk);
      end
    end
    n_checks++;
    if (!finished || acc != 1) begin
      n_fail++;
      $display("FAIL nv completion: finished=%0b words_taken=%0d expected 1 and 1", finished, acc);
    end
    valid_b = 1'b0;
    $display("txn no_verify: word %h expected chain 00111100", word);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_valid_stall();
    test_crc_error();
    test_mid_reset();
    test_start_ignored();
    test_random();
    test_no_verify();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
